// File: rtl/v_pkg.sv
// Shared types for the v_* list-query path: lookup field widths and the
// response record carried through the query-issue response FIFO.
package v_pkg;

   typedef logic [7:0]  id_t;
   typedef logic [3:0]  level_t;
   typedef logic [15:0] key_t;
   typedef logic [15:0] volume_t;
   typedef logic [7:0]  listsize_t;

   typedef struct packed {
      key_t      key;
      volume_t   volume;
      logic      error;
      listsize_t listsize;
   } query_rsp_t;

   localparam int QUERY_RESP_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/v_query_issue_if.sv
// Client request/response handshake plus the list-query pipe bus of v_query_issue.
// slave = the issue block itself, master = client and query pipe side.
interface v_query_issue_if
   import v_pkg::*;
#(
   parameter int TAG_W = 4
);
   logic             i_req_vld;
   id_t              i_req_prod_id;
   level_t           i_req_level;
   logic [TAG_W-1:0] i_req_tag;
   logic             o_req_rdy;

   logic             o_lut_vld;
   id_t              o_lut_prod_id;
   level_t           o_lut_level;
   key_t             i_lut_key;
   volume_t          i_lut_size;
   logic             i_lut_error;
   listsize_t        i_lut_listsize;

   logic             o_rsp_vld;
   logic             i_rsp_rdy;
   logic [TAG_W-1:0] o_rsp_tag;
   key_t             o_rsp_key;
   volume_t          o_rsp_size;
   logic             o_rsp_error;
   listsize_t        o_rsp_listsize;

   logic [15:0]      o_err_cnt;

   modport slave (
      input  i_req_vld, i_req_prod_id, i_req_level, i_req_tag,
      output o_req_rdy,
      output o_lut_vld, o_lut_prod_id, o_lut_level,
      input  i_lut_key, i_lut_size, i_lut_error, i_lut_listsize,
      output o_rsp_vld, o_rsp_tag, o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize,
      input  i_rsp_rdy,
      output o_err_cnt
   );

   modport master (
      output i_req_vld, i_req_prod_id, i_req_level, i_req_tag,
      input  o_req_rdy,
      input  o_lut_vld, o_lut_prod_id, o_lut_level,
      output i_lut_key, i_lut_size, i_lut_error, i_lut_listsize,
      input  o_rsp_vld, o_rsp_tag, o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize,
      output i_rsp_rdy,
      input  o_err_cnt
   );
endinterface

// File: rtl/v_query_rsp_fifo.sv
// In-order response FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate occupancy register.
module v_query_rsp_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 8,
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [IDX_W:0]   wr_ptr;
   logic [IDX_W:0]   rd_ptr;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [WIDTH-1:0] mem [DEPTH];

   // Index wraps at DEPTH-1 (not a power of two in general) and flips the wrap bit.
   function automatic logic [IDX_W:0] ptr_next(input logic [IDX_W:0] p);
      if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
         return {~p[IDX_W], {IDX_W{1'b0}}};
      return p + (IDX_W + 1)'(1);
   endfunction

   assign wr_idx    = wr_ptr[IDX_W-1:0];
   assign rd_idx    = rd_ptr[IDX_W-1:0];
   assign head_data = mem[rd_idx];
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (count == CNT_W'(DEPTH));

   always_comb begin
      count = CNT_W'(wr_idx) - CNT_W'(rd_idx);
      if (wr_ptr[IDX_W] != rd_ptr[IDX_W])
         count = count + CNT_W'(DEPTH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
      end else if (push) begin
         mem[wr_idx] <= push_data;
         wr_ptr      <= ptr_next(wr_ptr);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rd_ptr <= '0;
      else if (pop)
         rd_ptr <= ptr_next(rd_ptr);
   end

endmodule

// File: rtl/v_query_issue.sv
// Query-issue front end: issues client lookups to v_pipe_query and buffers results
// under a credit scheme. Optional error counter enabled by V_QUERY_ERRCNT_EN.
module v_query_issue
   import v_pkg::*;
#(
   parameter int RESP_DEPTH = QUERY_RESP_DEPTH_DEFAULT,
   parameter int TAG_W      = 4
) (
   input logic            clk,
   input logic            rst,
   v_query_issue_if.slave bus
);

   localparam int RSP_W = TAG_W + $bits(query_rsp_t);
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int OCC_W = CNT_W + 2;

   logic             a_vld;
   id_t              a_prod_id;
   level_t           a_level;
   logic [TAG_W-1:0] a_tag;
   logic             b_vld;
   logic [TAG_W-1:0] b_tag;

   logic             req_rdy;
   logic             accept;
   logic             push;
   logic             pop;
   logic             rsp_vld;
   logic [OCC_W-1:0] occ;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   query_rsp_t       lut_rsp;
   query_rsp_t       head_rsp;
   logic [RSP_W-1:0] push_data;
   logic [RSP_W-1:0] head_data;

   // Every lookup in stage A/B already owns a FIFO slot, so the pipe never needs to stall.
   assign occ     = OCC_W'(fifo_count) + OCC_W'(a_vld) + OCC_W'(b_vld);
   assign req_rdy = (occ < OCC_W'(RESP_DEPTH));
   assign accept  = bus.i_req_vld & req_rdy;
   assign rsp_vld = ~fifo_empty;
   assign pop     = rsp_vld & bus.i_rsp_rdy;
   assign push    = b_vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_vld     <= 1'b0;
         a_prod_id <= '0;
         a_level   <= '0;
         a_tag     <= '0;
      end else begin
         a_vld <= accept;
         if (accept) begin
            a_prod_id <= bus.i_req_prod_id;
            a_level   <= bus.i_req_level;
            a_tag     <= bus.i_req_tag;
         end
      end
   end

   // The pipe answers one cycle after o_lut_vld; b_tag lines the tag up with that answer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b_vld <= 1'b0;
         b_tag <= '0;
      end else begin
         b_vld <= a_vld;
         b_tag <= a_tag;
      end
   end

   assign lut_rsp = '{key:      bus.i_lut_key,
                      volume:   bus.i_lut_size,
                      error:    bus.i_lut_error,
                      listsize: bus.i_lut_listsize};
   assign push_data = {b_tag, lut_rsp};

   v_query_rsp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (RSP_W)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_rsp           = head_data[$bits(query_rsp_t)-1:0];
   assign bus.o_req_rdy      = req_rdy;
   assign bus.o_lut_vld      = a_vld;
   assign bus.o_lut_prod_id  = a_prod_id;
   assign bus.o_lut_level    = a_level;
   assign bus.o_rsp_vld      = rsp_vld;
   assign bus.o_rsp_tag      = head_data[RSP_W-1 -: TAG_W];
   assign bus.o_rsp_key      = head_rsp.key;
   assign bus.o_rsp_size     = head_rsp.volume;
   assign bus.o_rsp_error    = head_rsp.error;
   assign bus.o_rsp_listsize = head_rsp.listsize;

`ifdef V_QUERY_ERRCNT_EN
   logic [15:0] err_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_cnt <= '0;
      else if (push && bus.i_lut_error && (err_cnt != 16'hFFFF))
         err_cnt <= err_cnt + 16'd1;
   end

   assign bus.o_err_cnt = err_cnt;
`else
   assign bus.o_err_cnt = 16'd0;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_v_query_issue.sv
// Directed bench for v_query_issue: queue-based model of outstanding requests
// checked every cycle, plus hand-computed expectations per scenario.
module tb_v_query_issue;
   import v_pkg::*;

   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   v_query_issue_if #(.TAG_W(TAG_W)) bus ();

   v_query_issue #(
      .RESP_DEPTH (DEPTH),
      .TAG_W      (TAG_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Lookup contents the stand-in query pipe returns for (id, level).
   function automatic key_t pipe_key(input id_t id, input level_t lvl);
      return key_t'(id) * 16'd5 + key_t'(lvl >> 1);
   endfunction
   function automatic volume_t pipe_size(input id_t id);
      return volume_t'(id) * 16'd20;
   endfunction
   function automatic listsize_t pipe_ls(input level_t lvl);
      return listsize_t'(lvl) * 8'd2;
   endfunction
   function automatic logic pipe_err(input id_t id);
      return (id >= 8'hE0);
   endfunction

   logic   pipe_vld;
   id_t    pipe_id;
   level_t pipe_lvl;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld <= 1'b0;
         pipe_id  <= '0;
         pipe_lvl <= '0;
      end else begin
         pipe_vld <= bus.o_lut_vld;
         pipe_id  <= bus.o_lut_prod_id;
         pipe_lvl <= bus.o_lut_level;
      end
   end

   assign bus.i_lut_key      = pipe_vld ? pipe_key(pipe_id, pipe_lvl) : '0;
   assign bus.i_lut_size     = pipe_vld ? pipe_size(pipe_id) : '0;
   assign bus.i_lut_error    = pipe_vld ? pipe_err(pipe_id) : 1'b0;
   assign bus.i_lut_listsize = pipe_vld ? pipe_ls(pipe_lvl) : '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic vld, input id_t id, input level_t lvl,
                                input logic [TAG_W-1:0] tag, input logic rsp_rdy);
      bus.i_req_vld     = vld;
      bus.i_req_prod_id = id;
      bus.i_req_level   = lvl;
      bus.i_req_tag     = tag;
      bus.i_rsp_rdy     = rsp_rdy;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: every accepted request is outstanding until popped; it becomes the
   // visible head three cycles after its accept cycle.
   typedef struct {
      logic [TAG_W-1:0] tag;
      id_t              id;
      level_t           lvl;
      int               stamp;
   } exp_t;

   exp_t   expq[$];
   int     cyc = 0;
   logic   last_acc = 1'b0;
   id_t    last_id;
   level_t last_lvl;
   int     errs_popped = 0;
   int     exp_err;
   logic   exp_rsp;
   logic   m_acc;
   logic   m_pop;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            expq.delete();
            last_acc    = 1'b0;
            errs_popped = 0;
         end else begin
            checkOutput("model_req_rdy", 32'(bus.o_req_rdy), 32'(expq.size() < DEPTH));
            checkOutput("model_lut_vld", 32'(bus.o_lut_vld), 32'(last_acc));
            if (last_acc) begin
               checkOutput("model_lut_id", 32'(bus.o_lut_prod_id), 32'(last_id));
               checkOutput("model_lut_level", 32'(bus.o_lut_level), 32'(last_lvl));
            end
            exp_rsp = (expq.size() > 0) && (expq[0].stamp + 3 <= cyc);
            checkOutput("model_rsp_vld", 32'(bus.o_rsp_vld), 32'(exp_rsp));
            if (exp_rsp && bus.o_rsp_vld) begin
               checkOutput("model_rsp_tag", 32'(bus.o_rsp_tag), 32'(expq[0].tag));
               checkOutput("model_rsp_key", 32'(bus.o_rsp_key), 32'(pipe_key(expq[0].id, expq[0].lvl)));
               checkOutput("model_rsp_size", 32'(bus.o_rsp_size), 32'(pipe_size(expq[0].id)));
               checkOutput("model_rsp_error", 32'(bus.o_rsp_error), 32'(pipe_err(expq[0].id)));
               checkOutput("model_rsp_ls", 32'(bus.o_rsp_listsize), 32'(pipe_ls(expq[0].lvl)));
            end
            exp_err = errs_popped;
            foreach (expq[k])
               if ((expq[k].stamp + 3 <= cyc) && pipe_err(expq[k].id))
                  exp_err++;
`ifndef V_QUERY_ERRCNT_EN
            exp_err = 0;
`endif
            checkOutput("model_err_cnt", 32'(bus.o_err_cnt), 32'(exp_err));

            m_acc = bus.i_req_vld & bus.o_req_rdy;
            m_pop = bus.o_rsp_vld & bus.i_rsp_rdy;
            if (m_pop && (expq.size() > 0)) begin
               if (pipe_err(expq[0].id))
                  errs_popped++;
               void'(expq.pop_front());
            end
            if (m_acc)
               expq.push_back('{tag: bus.i_req_tag, id: bus.i_req_prod_id,
                                lvl: bus.i_req_level, stamp: cyc});
            last_acc = m_acc;
            last_id  = bus.i_req_prod_id;
            last_lvl = bus.i_req_level;
         end
      end
   end

   logic [TAG_W-1:0] tag;
   int               n_acc;
   int               n_rsp;
   int               first_t;
   int               last_t;
   int               drops;
   int               stale;
   logic [3:0]       err_seen;
   id_t              err_ids [4];

   initial begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      #2 rst = 1'b0;
      #1;
      $display("[TB] reset values");
      checkOutput("rst_req_rdy", 32'(bus.o_req_rdy), 32'd1);
      checkOutput("rst_lut_vld", 32'(bus.o_lut_vld), 32'd0);
      checkOutput("rst_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
      checkOutput("rst_err_cnt", 32'(bus.o_err_cnt), 32'd0);
      checkOutput("rst_lut_id", 32'(bus.o_lut_prod_id), 32'd0);
      checkOutput("rst_rsp_key", 32'(bus.o_rsp_key), 32'd0);
      step(2);
      rst = 1'b1;
      step(1);

      $display("[TB] single query");
      applyStimulus(1'b1, 8'd5, 4'd2, 4'd3, 1'b1);
      step(1);
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      checkOutput("sq_lut_vld_c1", 32'(bus.o_lut_vld), 32'd1);
      checkOutput("sq_lut_id_c1", 32'(bus.o_lut_prod_id), 32'd5);
      checkOutput("sq_lut_lvl_c1", 32'(bus.o_lut_level), 32'd2);
      step(1);
      checkOutput("sq_lut_vld_c2", 32'(bus.o_lut_vld), 32'd0);
      checkOutput("sq_rsp_vld_c2", 32'(bus.o_rsp_vld), 32'd0);
      step(1);
      checkOutput("sq_rsp_vld_c3", 32'(bus.o_rsp_vld), 32'd1);
      checkOutput("sq_rsp_tag", 32'(bus.o_rsp_tag), 32'd3);
      checkOutput("sq_rsp_key", 32'(bus.o_rsp_key), 32'h1A);
      checkOutput("sq_rsp_size", 32'(bus.o_rsp_size), 32'd100);
      checkOutput("sq_rsp_error", 32'(bus.o_rsp_error), 32'd0);
      checkOutput("sq_rsp_ls", 32'(bus.o_rsp_listsize), 32'd4);
      step(3);

      $display("[TB] back-pressure");
      tag   = '0;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'h10 + 8'(tag), 4'd1, tag, 1'b0);
         if (bus.o_req_rdy) begin
            n_acc++;
            tag++;
         end
         step(1);
      end
      checkOutput("bp_accepted", 32'(n_acc), 32'd4);
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      checkOutput("bp_rdy_low", 32'(bus.o_req_rdy), 32'd0);
      checkOutput("bp_tag0", 32'(bus.o_rsp_tag), 32'd0);
      step(1);
      checkOutput("bp_rdy_after_pop", 32'(bus.o_req_rdy), 32'd1);
      checkOutput("bp_tag1", 32'(bus.o_rsp_tag), 32'd1);
      step(1);
      checkOutput("bp_tag2", 32'(bus.o_rsp_tag), 32'd2);
      step(1);
      checkOutput("bp_tag3", 32'(bus.o_rsp_tag), 32'd3);
      step(1);
      checkOutput("bp_drained", 32'(bus.o_rsp_vld), 32'd0);
      step(2);

      $display("[TB] streaming");
      n_rsp   = 0;
      first_t = -1;
      last_t  = -1;
      drops   = 0;
      for (int t = 0; t < 26; t++) begin
         if (t < 20) begin
            applyStimulus(1'b1, 8'h20 + 8'(t), level_t'(t % 8), TAG_W'(t), 1'b1);
            if (!bus.o_req_rdy)
               drops++;
         end else begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
         end
         if (bus.o_rsp_vld) begin
            n_rsp++;
            if (first_t < 0)
               first_t = t;
            last_t = t;
         end
         step(1);
      end
      checkOutput("st_rdy_drops", 32'(drops), 32'd0);
      checkOutput("st_rsp_count", 32'(n_rsp), 32'd20);
      checkOutput("st_first_rsp", 32'(first_t), 32'd3);
      checkOutput("st_rsp_span", 32'(last_t - first_t), 32'd19);
      step(2);

      $display("[TB] error passthrough");
      err_ids  = '{8'h30, 8'hE1, 8'hE2, 8'h33};
      err_seen = '0;
      for (int t = 0; t < 10; t++) begin
         if (t < 4)
            applyStimulus(1'b1, err_ids[t], 4'd3, TAG_W'(t), 1'b1);
         else
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
         if (bus.o_rsp_vld)
            err_seen[bus.o_rsp_tag[1:0]] = bus.o_rsp_error;
         step(1);
      end
      checkOutput("err_flags", 32'(err_seen), 32'b0110);
`ifdef V_QUERY_ERRCNT_EN
      checkOutput("err_cnt", 32'(bus.o_err_cnt), 32'd2);
`else
      checkOutput("err_cnt", 32'(bus.o_err_cnt), 32'd0);
`endif

      $display("[TB] reset mid-flight");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'h40 + 8'(k), 4'd3, TAG_W'(5 + k), 1'b0);
         step(1);
      end
      applyStimulus(1'b0, '0, '0, '0, 1'b0);
      checkOutput("mr_pre_rsp_vld", 32'(bus.o_rsp_vld), 32'd1);
      checkOutput("mr_pre_lut_vld", 32'(bus.o_lut_vld), 32'd1);
      #1 rst = 1'b0;
      #1;
      checkOutput("mr_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
      checkOutput("mr_lut_vld", 32'(bus.o_lut_vld), 32'd0);
      step(1);
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      checkOutput("mr_rdy_after", 32'(bus.o_req_rdy), 32'd1);
      stale = 0;
      for (int t = 0; t < 8; t++) begin
         if (bus.o_rsp_vld)
            stale++;
         step(1);
      end
      checkOutput("mr_stale_rsp", 32'(stale), 32'd0);
      checkOutput("mr_err_cnt", 32'(bus.o_err_cnt), 32'd0);

      $display("[TB] push/pop at occupancy 3");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'h50 + 8'(k), 4'd4, TAG_W'(8 + k), 1'b0);
         step(1);
      end
      applyStimulus(1'b1, 8'h53, 4'd4, 4'd11, 1'b1);
      checkOutput("o3_rdy_c3", 32'(bus.o_req_rdy), 32'd1);
      checkOutput("o3_tag8", 32'(bus.o_rsp_tag), 32'd8);
      step(1);
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      checkOutput("o3_rdy_c4", 32'(bus.o_req_rdy), 32'd1);
      checkOutput("o3_tag9", 32'(bus.o_rsp_tag), 32'd9);
      step(8);
      checkOutput("o3_drained", 32'(bus.o_rsp_vld), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
